// File: rtl/multi_zone_parking_ctrl_if.sv
// Signal bundle between a parking lot controller and its gate hardware.
//   master : gate/sensor side. Drives entry_sensor, exit_sensor, exit_zone
//            and observes the gate and status outputs.
//   slave  : controller side. Consumes the sensors and drives entry_gate,
//            exit_gate, assigned_zone, assign_valid, entry_denied, exit_err,
//            zone_full, free_total, lot_full and lot_empty.
interface multi_zone_parking_ctrl_if #(
  parameter int ZONES    = 4,
  parameter int ZONE_CAP = 20
);
  localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int FW = $clog2(ZONES * ZONE_CAP + 1);

  logic          entry_sensor;
  logic          exit_sensor;
  logic [ZW-1:0] exit_zone;
  logic          entry_gate;
  logic          exit_gate;
  logic [ZW-1:0] assigned_zone;
  logic          assign_valid;
  logic          entry_denied;
  logic          exit_err;
  logic [ZONES-1:0] zone_full;
  logic [FW-1:0] free_total;
  logic          lot_full;
  logic          lot_empty;

  modport master (
    output entry_sensor, exit_sensor, exit_zone,
    input  entry_gate, exit_gate, assigned_zone, assign_valid, entry_denied,
           exit_err, zone_full, free_total, lot_full, lot_empty
  );

  modport slave (
    input  entry_sensor, exit_sensor, exit_zone,
    output entry_gate, exit_gate, assigned_zone, assign_valid, entry_denied,
           exit_err, zone_full, free_total, lot_full, lot_empty
  );
endinterface

// File: rtl/multi_zone_parking_ctrl.sv
// Multi-zone parking lot controller.
// Tracks per-zone occupancy, allocates each admitted car to the lowest-index
// zone with space, and runs independent entry and exit barrier FSMs with a
// minimum gate-open time of GATE_CYCLES clocks.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous, active-high
//   bus   : multi_zone_parking_ctrl_if.slave (sensors in, gates/status out)
module multi_zone_parking_ctrl #(
  parameter int ZONES       = 4,
  parameter int ZONE_CAP    = 20,
  parameter int GATE_CYCLES = 25000
) (
  input  logic clk,
  input  logic reset,
  multi_zone_parking_ctrl_if.slave bus
);

  localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int FW = $clog2(ZONES * ZONE_CAP + 1);
  localparam int CW = $clog2(ZONE_CAP + 1);
  localparam int TW = $clog2(GATE_CYCLES);

  localparam logic [CW-1:0] CAP   = CW'(ZONE_CAP);
  localparam logic [FW-1:0] TOTAL = FW'(ZONES * ZONE_CAP);
  localparam logic [TW-1:0] TLOAD = TW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OPEN, HOLD, DENY} gate_state_t;

  gate_state_t en_state, ex_state;
  logic [TW-1:0] en_timer, ex_timer;
  logic [CW-1:0] occ [ZONES];

  logic          entry_gate_r, exit_gate_r;
  logic [ZW-1:0] assigned_zone_r;
  logic          assign_valid_r, entry_denied_r, exit_err_r;

  logic [ZONES-1:0] zone_full_v;
  logic [FW-1:0]    free_sum;
  logic [ZW-1:0]    alloc_zone;
  logic             alloc_found;
  logic             exit_ok;
  logic             lot_full;
  logic             admit, release_car;
  logic [ZONES-1:0] inc_vec, dec_vec;

  // Status, allocation and exit validity all derive from registered counts,
  // so a release only becomes visible to admission one cycle later.
  always_comb begin
    zone_full_v = '0;
    free_sum    = '0;
    alloc_zone  = '0;
    alloc_found = 1'b0;
    exit_ok     = 1'b0;
    for (int unsigned z = 0; z < ZONES; z++) begin
      if (occ[z] == CAP) zone_full_v[z] = 1'b1;
      free_sum = free_sum + FW'(CAP - occ[z]);
      if (!alloc_found && occ[z] != CAP) begin
        alloc_zone  = ZW'(z);
        alloc_found = 1'b1;
      end
      // Out-of-range exit_zone values never match, so they read as invalid.
      if (bus.exit_zone == ZW'(z) && occ[z] != '0) exit_ok = 1'b1;
    end
  end

  assign lot_full    = (free_sum == '0);
  assign admit       = bus.entry_sensor && !lot_full &&
                       (en_state == IDLE || en_state == DENY);
  assign release_car = bus.exit_sensor && exit_ok && (ex_state == IDLE);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned z = 0; z < ZONES; z++) begin
      inc_vec[z] = admit && (alloc_zone == ZW'(z));
      dec_vec[z] = release_car && (bus.exit_zone == ZW'(z));
    end
  end

  // A simultaneous admit and release on one zone cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned z = 0; z < ZONES; z++) occ[z] <= '0;
    end else begin
      for (int unsigned z = 0; z < ZONES; z++) begin
        if (inc_vec[z] && !dec_vec[z])      occ[z] <= occ[z] + CW'(1);
        else if (dec_vec[z] && !inc_vec[z]) occ[z] <= occ[z] - CW'(1);
      end
    end
  end

  // Entry FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_state        <= IDLE;
      en_timer        <= '0;
      entry_gate_r    <= 1'b0;
      assigned_zone_r <= '0;
      assign_valid_r  <= 1'b0;
      entry_denied_r  <= 1'b0;
    end else begin
      assign_valid_r <= 1'b0;
      if (admit) begin
        en_state        <= OPEN;
        en_timer        <= TLOAD;
        entry_gate_r    <= 1'b1;
        entry_denied_r  <= 1'b0;
        assigned_zone_r <= alloc_zone;
        assign_valid_r  <= 1'b1;
      end else begin
        case (en_state)
          IDLE: if (bus.entry_sensor) begin
            en_state       <= DENY;
            entry_denied_r <= 1'b1;
          end
          DENY: if (!bus.entry_sensor) begin
            en_state       <= IDLE;
            entry_denied_r <= 1'b0;
          end
          OPEN: begin
            if (en_timer == '0) begin
              if (bus.entry_sensor) begin
                en_state <= HOLD;
              end else begin
                en_state     <= IDLE;
                entry_gate_r <= 1'b0;
              end
            end else begin
              en_timer <= en_timer - TW'(1);
            end
          end
          HOLD: if (!bus.entry_sensor) begin
            en_state     <= IDLE;
            entry_gate_r <= 1'b0;
          end
          default: begin
            en_state       <= IDLE;
            entry_gate_r   <= 1'b0;
            entry_denied_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Exit FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_state    <= IDLE;
      ex_timer    <= '0;
      exit_gate_r <= 1'b0;
      exit_err_r  <= 1'b0;
    end else begin
      exit_err_r <= 1'b0;
      case (ex_state)
        IDLE: if (bus.exit_sensor) begin
          if (exit_ok) begin
            ex_state    <= OPEN;
            ex_timer    <= TLOAD;
            exit_gate_r <= 1'b1;
          end else begin
            ex_state   <= DENY;
            exit_err_r <= 1'b1;
          end
        end
        DENY: if (!bus.exit_sensor) ex_state <= IDLE;
        OPEN: begin
          if (ex_timer == '0) begin
            if (bus.exit_sensor) begin
              ex_state <= HOLD;
            end else begin
              ex_state    <= IDLE;
              exit_gate_r <= 1'b0;
            end
          end else begin
            ex_timer <= ex_timer - TW'(1);
          end
        end
        HOLD: if (!bus.exit_sensor) begin
          ex_state    <= IDLE;
          exit_gate_r <= 1'b0;
        end
        default: begin
          ex_state    <= IDLE;
          exit_gate_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.entry_gate    = entry_gate_r;
  assign bus.exit_gate     = exit_gate_r;
  assign bus.assigned_zone = assigned_zone_r;
  assign bus.assign_valid  = assign_valid_r;
  assign bus.entry_denied  = entry_denied_r;
  assign bus.exit_err      = exit_err_r;
  assign bus.zone_full     = zone_full_v;
  assign bus.free_total    = free_sum;
  assign bus.lot_full      = lot_full;
  assign bus.lot_empty     = (free_sum == TOTAL);

endmodule
